l1d_tag_update_ctrl: RTL and testbench

L1D_TAG_UPDATE_CTRL -- requirements
Module: l1d_tag_update_ctrl

---
 rtl/l1d_tag_update_ctrl_pkg.sv | 21 ++
 rtl/l1d_tag_update_ctrl_if.sv | 64 ++++++
 rtl/l1d_tag_update_ctrl.sv | 118 +++++++++++
 tb/tb_l1d_tag_update_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1d_tag_update_ctrl_pkg.sv
// Shared L1D defines: geometry, index/tag types and the L2 response record
// consumed by the tag-update controller.
package l1d_tag_update_ctrl_pkg;

  localparam int L1D_WAYS  = 4;
  localparam int L1D_SETS  = 64;
  localparam int L1D_TAG_W = 20;
  localparam int L1D_SET_W = $clog2(L1D_SETS);
  localparam int L1D_WAY_W = $clog2(L1D_WAYS);

  typedef logic [L1D_SET_W-1:0] l1d_set_idx_t;
  typedef logic [L1D_TAG_W-1:0] l1d_tag_t;
  typedef logic [L1D_WAY_W-1:0] l1d_way_idx_t;

  typedef struct packed {
    logic         is_fill;
    l1d_set_idx_t set;
    l1d_tag_t     tag;
  } l1d_resp_t;

endpackage

// File: rtl/l1d_tag_update_ctrl_if.sv
// Bundle of the L2 response channel, tag-array snoop/LRU/update ports and the
// completion/eviction outputs of the L1D tag-update controller.
interface l1d_tag_update_ctrl_if
  import l1d_tag_update_ctrl_pkg::*;
#(
  parameter int NUM_WAYS = L1D_WAYS,
  parameter int NUM_SETS = L1D_SETS,
  parameter int TAG_W    = L1D_TAG_W
);
  localparam int SET_W = $clog2(NUM_SETS);
  localparam int WAY_W = $clog2(NUM_WAYS);

  // resp_* transfers on a rising edge where resp_valid && resp_ready; the
  // payload must hold while resp_valid is high and ready is low, and ready
  // may depend combinationally on resp_set.
  logic                resp_valid;
  logic                resp_ready;
  logic                resp_is_fill;
  logic [SET_W-1:0]    resp_set;
  logic [TAG_W-1:0]    resp_tag;

  logic                l2i_snoop_en;
  logic [SET_W-1:0]    l2i_snoop_set;
  logic                l2i_dcache_lru_fill_en;
  logic [SET_W-1:0]    l2i_dcache_lru_fill_set;

  logic [NUM_WAYS-1:0] dt_snoop_valid;
  logic [TAG_W-1:0]    dt_snoop_tag [NUM_WAYS];
  logic [WAY_W-1:0]    dt_fill_lru;

  logic [NUM_WAYS-1:0] l2i_dtag_update_en_oh;
  logic [SET_W-1:0]    l2i_dtag_update_set;
  logic [TAG_W-1:0]    l2i_dtag_update_tag;
  logic                l2i_dtag_update_valid;

  logic                done_valid;
  logic [WAY_W-1:0]    done_way;
  logic                done_hit;
  logic                done_is_fill;

  logic                evict_valid;
  logic [TAG_W-1:0]    evict_tag;

  modport slave (
    input  resp_valid, resp_is_fill, resp_set, resp_tag,
    input  dt_snoop_valid, dt_snoop_tag, dt_fill_lru,
    output resp_ready,
    output l2i_snoop_en, l2i_snoop_set, l2i_dcache_lru_fill_en, l2i_dcache_lru_fill_set,
    output l2i_dtag_update_en_oh, l2i_dtag_update_set, l2i_dtag_update_tag, l2i_dtag_update_valid,
    output done_valid, done_way, done_hit, done_is_fill,
    output evict_valid, evict_tag
  );

  modport master (
    output resp_valid, resp_is_fill, resp_set, resp_tag,
    output dt_snoop_valid, dt_snoop_tag, dt_fill_lru,
    input  resp_ready,
    input  l2i_snoop_en, l2i_snoop_set, l2i_dcache_lru_fill_en, l2i_dcache_lru_fill_set,
    input  l2i_dtag_update_en_oh, l2i_dtag_update_set, l2i_dtag_update_tag, l2i_dtag_update_valid,
    input  done_valid, done_way, done_hit, done_is_fill,
    input  evict_valid, evict_tag
  );

endinterface

// File: rtl/l1d_tag_update_ctrl.sv
// Two-stage L1D tag update: snoop + LRU request on acceptance, then hit/victim
// resolution and a single tag write with completion one cycle later.
module l1d_tag_update_ctrl
  import l1d_tag_update_ctrl_pkg::*;
#(
  parameter int NUM_WAYS = L1D_WAYS,
  parameter int NUM_SETS = L1D_SETS,
  parameter int TAG_W    = L1D_TAG_W
) (
  input logic                  clk,
  input logic                  reset_n,
  l1d_tag_update_ctrl_if.slave bus
);

  localparam int SET_W = $clog2(NUM_SETS);

  // The record and index types come from the shared package, so the
  // geometry parameters have to agree with it.
  if (NUM_WAYS != L1D_WAYS || SET_W != L1D_SET_W || TAG_W != L1D_TAG_W) begin : g_geom_check
    $error("l1d_tag_update_ctrl geometry does not match l1d_tag_update_ctrl_pkg");
  end

  function automatic l1d_way_idx_t hit_way_enc(input logic [NUM_WAYS-1:0] hits);
    l1d_way_idx_t way;
    way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (hits[w]) way = l1d_way_idx_t'(w);
    end
    return way;
  endfunction

  logic                accept;
  logic                s1_valid_q, s1_valid_d;
  l1d_resp_t           s1_q, s1_d;
  logic [NUM_WAYS-1:0] hit_vec;
  logic                hit_any;
  l1d_way_idx_t        hit_way;
  l1d_way_idx_t        lru_way;

  // One bubble when the incoming set is the one being written this cycle.
  assign bus.resp_ready = reset_n && !(s1_valid_q && (bus.resp_set == s1_q.set));
  assign accept         = bus.resp_valid && bus.resp_ready;

  assign bus.l2i_snoop_en            = accept;
  assign bus.l2i_snoop_set           = accept ? bus.resp_set : '0;
  assign bus.l2i_dcache_lru_fill_en  = accept && bus.resp_is_fill;
  assign bus.l2i_dcache_lru_fill_set = (accept && bus.resp_is_fill) ? bus.resp_set : '0;

  always_comb begin
    s1_valid_d = accept;
    s1_d       = s1_q;
    if (accept) begin
      s1_d.is_fill = bus.resp_is_fill;
      s1_d.set     = bus.resp_set;
      s1_d.tag     = bus.resp_tag;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
    end
  end

  always_comb begin
    hit_vec = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      hit_vec[w] = bus.dt_snoop_valid[w] && (bus.dt_snoop_tag[w] == s1_q.tag);
    end
  end

  assign hit_any = |hit_vec;
  assign hit_way = hit_way_enc(hit_vec);
  assign lru_way = bus.dt_fill_lru;

  always_comb begin
    bus.l2i_dtag_update_en_oh = '0;
    bus.l2i_dtag_update_set   = '0;
    bus.l2i_dtag_update_tag   = '0;
    bus.l2i_dtag_update_valid = 1'b0;
    bus.done_valid            = 1'b0;
    bus.done_way              = '0;
    bus.done_hit              = 1'b0;
    bus.done_is_fill          = 1'b0;
    bus.evict_valid           = 1'b0;
    bus.evict_tag             = '0;
    if (s1_valid_q) begin
      bus.done_valid          = 1'b1;
      bus.done_is_fill        = s1_q.is_fill;
      bus.l2i_dtag_update_set = s1_q.set;
      bus.l2i_dtag_update_tag = s1_q.tag;
      if (hit_any) begin
        // A fill that hits refreshes the resident way; an invalidate clears it.
        bus.l2i_dtag_update_en_oh = hit_vec;
        bus.l2i_dtag_update_valid = s1_q.is_fill;
        bus.done_way              = hit_way;
        bus.done_hit              = 1'b1;
      end else if (s1_q.is_fill) begin
        bus.l2i_dtag_update_en_oh = {{(NUM_WAYS-1){1'b0}}, 1'b1} << lru_way;
        bus.l2i_dtag_update_valid = 1'b1;
        bus.done_way              = lru_way;
        bus.evict_valid           = bus.dt_snoop_valid[lru_way];
        bus.evict_tag             = bus.dt_snoop_tag[lru_way];
      end
    end
  end

  a_single_hit: assert property (@(posedge clk) disable iff (!reset_n)
    s1_valid_q |-> $onehot0(hit_vec));

  a_en_onehot0: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(bus.l2i_dtag_update_en_oh));

endmodule

// File: tb/tb_l1d_tag_update_ctrl.sv
// Bench for l1d_tag_update_ctrl: a behavioural tag store drives the snoop
// results, a reference model predicts each completion, a monitor checks them.
module tb_l1d_tag_update_ctrl;
  import l1d_tag_update_ctrl_pkg::*;

  localparam int W  = L1D_WAYS;
  localparam int S  = L1D_SETS;
  localparam int TW = L1D_TAG_W;

  typedef struct packed {
    logic [31:0]  due;
    logic [W-1:0] en;
    l1d_set_idx_t set;
    l1d_tag_t     tag;
    logic         uv;
    l1d_way_idx_t way;
    logic         hit;
    logic         fill;
    logic         ev;
    l1d_tag_t     evtag;
  } exp_t;

  logic   clk;
  logic   reset_n;
  int     cyc;
  int     n_checks;
  int     n_fail;
  exp_t   exp_q[$];

  bit       st_vld [S][W];
  l1d_tag_t st_tag [S][W];

  int last_acc;
  int last_set;

  l1d_tag_update_ctrl_if bus ();

  l1d_tag_update_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        check("reset_resp_ready", bus.resp_ready, 0);
        check("reset_snoop_en", bus.l2i_snoop_en, 0);
        check("reset_lru_en", bus.l2i_dcache_lru_fill_en, 0);
      end
      if (bus.done_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("done_cycle", cyc, e.due);
          check("upd_en_oh", bus.l2i_dtag_update_en_oh, e.en);
          check("upd_set", bus.l2i_dtag_update_set, e.set);
          check("upd_tag", bus.l2i_dtag_update_tag, e.tag);
          check("upd_valid", bus.l2i_dtag_update_valid, e.uv);
          check("done_way", bus.done_way, e.way);
          check("done_hit", bus.done_hit, e.hit);
          check("done_is_fill", bus.done_is_fill, e.fill);
          check("evict_valid", bus.evict_valid, e.ev);
          if (e.ev) check("evict_tag", bus.evict_tag, e.evtag);
        end
      end else begin
        check("idle_done_valid", bus.done_valid, 0);
        check("idle_en_oh", bus.l2i_dtag_update_en_oh, 0);
        check("idle_evict_valid", bus.evict_valid, 0);
      end
    end
  end

  // driver: entered and left on a falling edge
  task automatic send(input bit fill, input int set, input int tag, input int lru);
    int       waits;
    int       exp_stall;
    int       hw;
    exp_t     e;
    bit       sv [W];
    l1d_tag_t stg [W];
    exp_stall = (cyc == last_acc + 1 && set == last_set) ? 1 : 0;
    bus.resp_valid   = 1'b1;
    bus.resp_is_fill = fill;
    bus.resp_set     = l1d_set_idx_t'(set);
    bus.resp_tag     = l1d_tag_t'(tag);
    #1;
    waits = 0;
    while (bus.resp_ready !== 1'b1 && waits < 8) begin
      @(negedge clk);
      #1;
      waits++;
    end
    check("stall_cycles", waits, exp_stall);
    if (bus.resp_ready !== 1'b1) begin
      bus.resp_valid = 1'b0;
      return;
    end
    check("snoop_en", bus.l2i_snoop_en, 1);
    check("snoop_set", bus.l2i_snoop_set, set);
    check("lru_fill_en", bus.l2i_dcache_lru_fill_en, fill);
    if (fill) check("lru_fill_set", bus.l2i_dcache_lru_fill_set, set);

    // reference model: look the tag up in the store, then apply the update
    hw = -1;
    for (int w = 0; w < W; w++) begin
      sv[w]  = st_vld[set][w];
      stg[w] = sv[w] ? st_tag[set][w] : l1d_tag_t'($urandom);
      if (sv[w] && stg[w] == l1d_tag_t'(tag) && hw < 0) hw = w;
    end
    e.due  = 32'(cyc + 1);
    e.set  = l1d_set_idx_t'(set);
    e.tag  = l1d_tag_t'(tag);
    e.fill = fill;
    e.evtag = '0;
    if (hw >= 0) begin
      e.en = W'(1) << hw;  e.way = l1d_way_idx_t'(hw); e.hit = 1'b1; e.uv = fill; e.ev = 1'b0;
    end else if (fill) begin
      e.en = W'(1) << lru; e.way = l1d_way_idx_t'(lru); e.hit = 1'b0; e.uv = 1'b1;
      e.ev = sv[lru]; e.evtag = stg[lru];
    end else begin
      e.en = '0; e.way = '0; e.hit = 1'b0; e.uv = 1'b0; e.ev = 1'b0;
    end
    exp_q.push_back(e);
    if (fill) begin
      st_vld[set][e.way] = 1'b1;
      st_tag[set][e.way] = l1d_tag_t'(tag);
    end else if (hw >= 0) begin
      st_vld[set][hw] = 1'b0;
    end
    last_acc = cyc;
    last_set = set;

    @(posedge clk);
    #1;
    for (int w = 0; w < W; w++) begin
      bus.dt_snoop_valid[w] = sv[w];
      bus.dt_snoop_tag[w]   = stg[w];
    end
    bus.dt_fill_lru = l1d_way_idx_t'(lru);
    bus.resp_valid  = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_set(input int set);
    for (int w = 0; w < W; w++) st_vld[set][w] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // stimulus
  initial begin
    n_checks = 0;
    n_fail   = 0;
    last_acc = -10;
    last_set = -1;
    reset_n  = 1'b0;
    bus.resp_valid     = 1'b0;
    bus.resp_is_fill   = 1'b0;
    bus.resp_set       = '0;
    bus.resp_tag       = '0;
    bus.dt_snoop_valid = '0;
    bus.dt_fill_lru    = '0;
    for (int w = 0; w < W; w++) bus.dt_snoop_tag[w] = '0;

    idle(3);
    reset_n = 1'b1;
    idle(1);
    #1;
    check("ready_after_reset", bus.resp_ready, 1);
    check("done_after_reset", bus.done_valid, 0);
    idle(1);

    // fill to an empty set takes the LRU way without eviction
    clear_set(5);
    send(1'b1, 5, 'h1234, 2);
    // fill that hits way 1 ignores the LRU way (same set: one bubble)
    clear_set(5);
    st_vld[5][1] = 1'b1;
    st_tag[5][1] = l1d_tag_t'('h1234);
    send(1'b1, 5, 'h1234, 3);
    // fill that displaces a valid line
    clear_set(7);
    st_vld[7][3] = 1'b1;
    st_tag[7][3] = l1d_tag_t'('h0F0F);
    send(1'b1, 7, 'hAAAA, 3);
    // invalidate miss
    clear_set(9);
    send(1'b0, 9, 'h55, 1);
    // invalidate hit
    send(1'b0, 7, 'hAAAA, 0);
    idle(2);
    // same-set hazard then differing sets
    send(1'b1, 3, 'h10, 0);
    send(1'b1, 3, 'h11, 1);
    send(1'b1, 4, 'h12, 2);
    idle(2);

    // reset lands in C+1 of an accepted fill: no write may follow
    bus.resp_valid   = 1'b1;
    bus.resp_is_fill = 1'b1;
    bus.resp_set     = l1d_set_idx_t'(2);
    bus.resp_tag     = l1d_tag_t'('h77);
    #1;
    check("rst_case_ready", bus.resp_ready, 1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    bus.resp_set = l1d_set_idx_t'(11);
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      check("rst_done_valid", bus.done_valid, 0);
      check("rst_en_oh", bus.l2i_dtag_update_en_oh, 0);
      check("rst_upd_valid", bus.l2i_dtag_update_valid, 0);
      check("rst_evict_valid", bus.evict_valid, 0);
    end
    bus.resp_valid = 1'b0;
    reset_n  = 1'b1;
    last_acc = -10;
    idle(3);

    // randomized traffic, mostly on a few sets to exercise hits and hazards
    for (int i = 0; i < 300; i++) begin
      bit fill;
      int set;
      fill = ($urandom_range(0, 3) != 0);
      set  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, S - 1)) : int'($urandom_range(0, 3));
      send(fill, set, int'($urandom_range(0, 5)), int'($urandom_range(0, W - 1)));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end

    idle(4);
    check("exp_q_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
